// File: rtl/paddle_emulator_pkg.sv
// paddle_emulator_pkg: shared channel FSM encoding and defaults for paddle_emulator.
// PE_ACCEL_MULT is the fast-step multiplier used when PADDLE_ACCEL_EN is defined.
package paddle_emulator_pkg;
   typedef enum logic [1:0] {PE_IDLE, PE_ARMED, PE_FIRED} pe_state_t;
   localparam int PE_CENTER     = 128;
   localparam int PE_ACCEL_MULT = 4;
endpackage

// File: rtl/paddle_emu_channel.sv
// paddle_emu_channel: one paddle axis with a position counter, a frame shadow and a fire FSM.
// PADDLE_ACCEL_EN adds a hold counter that switches to a fast step after ACCEL_FRAMES held frames.
module paddle_emu_channel
   import paddle_emulator_pkg::*;
#(
   parameter int STEP         = 1,
   parameter int MIN_POS      = 0,
   parameter int MAX_POS      = 239,
   parameter int CENTER       = PE_CENTER,
   parameter int ACCEL_FRAMES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fs,
   input  logic       up,
   input  logic       down,
   input  logic [8:0] hpos,
   input  logic [8:0] vpos,
   output logic       paddle,
   output logic [7:0] pos
);
   pe_state_t  state, state_nxt;
   logic [7:0] shadow, pos_nxt;
   logic [8:0] step;
   logic [9:0] sum, dif;

   if (ACCEL_FRAMES < 1 || ACCEL_FRAMES > 31) begin : g_bad_accel
      $error("ACCEL_FRAMES must fit the 5-bit hold counter");
   end

`ifdef PADDLE_ACCEL_EN
   logic [4:0] hold;
   assign step = (hold == 5'(ACCEL_FRAMES)) ? 9'(PE_ACCEL_MULT * STEP) : 9'(STEP);
   always_ff @(posedge clk or negedge reset)
      if (!reset) hold <= '0;
      else if (fs) hold <= !(up ^ down) ? 5'd0 : (hold == 5'(ACCEL_FRAMES)) ? hold : hold + 5'd1;
`else
   assign step = 9'(STEP);
`endif

   // Widened arithmetic so saturation is decided before any 8-bit truncation.
   assign sum = {2'b0, pos} + {1'b0, step};
   assign dif = {2'b0, pos} - {1'b0, step};
   assign pos_nxt = (up && !down) ? ((sum > 10'(MAX_POS)) ? 8'(MAX_POS) : sum[7:0])
                  : (down && !up) ? ((dif[9] || dif < 10'(MIN_POS)) ? 8'(MIN_POS) : dif[7:0])
                  : pos;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos    <= 8'(CENTER);
         shadow <= 8'(CENTER);
         state  <= PE_IDLE;
      end else begin
         if (fs) begin
            pos    <= pos_nxt;
            shadow <= pos_nxt;
         end
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      paddle    = (state == PE_FIRED);
      if (fs) state_nxt = PE_ARMED;
      else if (state == PE_ARMED && hpos == 9'd0 && vpos == {1'b0, shadow}) state_nxt = PE_FIRED;
   end
endmodule

// File: rtl/paddle_emulator.sv
// paddle_emulator: emulates RC paddle comparator pulses from button-driven positions.
// Optional PADDLE_ACCEL_EN enables per-axis hold acceleration inside each channel.
module paddle_emulator
   import paddle_emulator_pkg::*;
#(
   parameter int STEP         = 1,
   parameter int MIN_POS      = 0,
   parameter int MAX_POS      = 239,
   parameter int CENTER       = PE_CENTER,
   parameter int ACCEL_FRAMES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] hpos,
   input  logic [8:0] vpos,
   input  logic       vsync,
   input  logic       x_up,
   input  logic       x_down,
   input  logic       y_up,
   input  logic       y_down,
   output logic       hpaddle,
   output logic       vpaddle,
   output logic [7:0] pos_x,
   output logic [7:0] pos_y
);
   logic vsync_q, fs;

   always_ff @(posedge clk or negedge reset)
      if (!reset) vsync_q <= 1'b0;
      else vsync_q <= vsync;

   assign fs = vsync && !vsync_q;

   paddle_emu_channel #(.STEP(STEP), .MIN_POS(MIN_POS), .MAX_POS(MAX_POS), .CENTER(CENTER),
                        .ACCEL_FRAMES(ACCEL_FRAMES)) u_x (
      .clk(clk), .reset(reset), .fs(fs), .up(x_up), .down(x_down),
      .hpos(hpos), .vpos(vpos), .paddle(hpaddle), .pos(pos_x));

   paddle_emu_channel #(.STEP(STEP), .MIN_POS(MIN_POS), .MAX_POS(MAX_POS), .CENTER(CENTER),
                        .ACCEL_FRAMES(ACCEL_FRAMES)) u_y (
      .clk(clk), .reset(reset), .fs(fs), .up(y_up), .down(y_down),
      .hpos(hpos), .vpos(vpos), .paddle(vpaddle), .pos(pos_y));
endmodule
